// File: rtl/move_collector.sv
// Tic-tac-toe move collector: debounces nine cell buttons, alternates P1/P2 turns,
// builds the 18-bit board bus and reacts to the detector's win/draw result.
module move_collector #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:1]  btn,
    input  logic        new_game,
    input  logic [3:1]  w,
    output logic [18:1] sw,
    output logic [8:0]  b,
    output logic        turn,
    output logic        game_over,
    output logic [1:0]  winner,
    output logic        illegal
);

    localparam logic [1:0] P_TURN    = 2'd0;
    localparam logic [1:0] CHECK     = 2'd1;
    localparam logic [1:0] GAME_OVER = 2'd2;

    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [3:0]       MAX_MOVES = 4'd9;

    logic [9:1]       sync_a, sync_b, sync_last;
    logic [CNT_W-1:0] db_cnt;
    logic [9:1]       db_vec, db_prev;
    logic [9:1]       press;

    logic [1:0]  state, state_n;
    logic [18:1] sw_n;
    logic [8:0]  b_n;
    logic        turn_n;
    logic [1:0]  winner_n;
    logic        illegal_n;
    logic        game_over_n;
    logic [3:0]  move_cnt, move_cnt_n;
    logic [9:1]  occ;

    // Synchroniser and debounce; a vector is accepted only after it has been stable long enough
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a    <= '0;
            sync_b    <= '0;
            sync_last <= '0;
            db_cnt    <= '0;
            db_vec    <= '0;
            db_prev   <= '0;
        end else begin
            sync_a    <= btn;
            sync_b    <= sync_a;
            sync_last <= sync_b;
            if (sync_b != sync_last) begin
                db_cnt <= '0;
            end else if (db_cnt != DB_LIMIT) begin
                db_cnt <= db_cnt + 1'b1;
            end else begin
                db_vec <= sync_last;
            end
            db_prev <= db_vec;
        end
    end

    assign press = db_vec & ~db_prev;

    always_comb begin
        for (int k = 1; k <= 9; k++) begin
            occ[k] = sw[2*k-1] | sw[2*k];
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        sw_n        = sw;
        b_n         = b;
        turn_n      = turn;
        winner_n    = winner;
        illegal_n   = 1'b0;
        move_cnt_n  = move_cnt;
        game_over_n = 1'b0;

        case (state)
            P_TURN: begin
                if (press != '0) begin
                    if ($onehot(press) && ((press & occ) == '0)) begin
                        for (int k = 1; k <= 9; k++) begin
                            if (press[k] && !turn) sw_n[2*k-1] = 1'b1;
                            if (press[k] && turn)  sw_n[2*k]   = 1'b1;
                        end
                        move_cnt_n = (move_cnt == MAX_MOVES) ? MAX_MOVES : move_cnt + 4'd1;
                        state_n    = CHECK;
                    end else begin
                        illegal_n = 1'b1;
                    end
                end
            end
            CHECK: begin
                // A win is checked before the move count so a 9th-move win is never a draw
                if (w[1]) begin
                    winner_n = 2'b01;
                    state_n  = GAME_OVER;
                end else if (w[2]) begin
                    winner_n = 2'b10;
                    state_n  = GAME_OVER;
                end else if (move_cnt == MAX_MOVES) begin
                    winner_n = 2'b11;
                    b_n      = 9'h1FF;
                    state_n  = GAME_OVER;
                end else begin
                    turn_n  = ~turn;
                    state_n = P_TURN;
                end
            end
            GAME_OVER: begin
                state_n = GAME_OVER;
            end
            default: begin
                state_n = P_TURN;
            end
        endcase

        if (new_game) begin
            state_n    = P_TURN;
            sw_n       = '0;
            b_n        = '0;
            turn_n     = 1'b0;
            winner_n   = 2'b00;
            illegal_n  = 1'b0;
            move_cnt_n = '0;
        end

        game_over_n = (state_n == GAME_OVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= P_TURN;
            sw        <= '0;
            b         <= '0;
            turn      <= 1'b0;
            winner    <= 2'b00;
            illegal   <= 1'b0;
            game_over <= 1'b0;
            move_cnt  <= '0;
        end else begin
            state     <= state_n;
            sw        <= sw_n;
            b         <= b_n;
            turn      <= turn_n;
            winner    <= winner_n;
            illegal   <= illegal_n;
            game_over <= game_over_n;
            move_cnt  <= move_cnt_n;
        end
    end

endmodule
